// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM write path: address width, drain FSM
// encoding and the issue guard constant, also used by the refill logic.
package sdram_pkg;

    localparam int unsigned AW = 26;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } drain_state_e;

    // Cycles spent in ISSUE while the controller is still showing a stale o_ready.
    localparam logic [1:0] GUARD_INIT = 2'd2;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head read and registered full/empty/level.
module sync_fifo #(
    parameter int unsigned WIDTH = 34,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             do_push, do_pop;

    assign do_push = push_i && !full_q;
    assign do_pop  = pop_i && !empty_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        if (do_push && !do_pop)      level_d = level_q + LW'(1);
        else if (!do_push && do_pop) level_d = level_q - LW'(1);
        full_d  = (level_d == LW'(DEPTH));
        empty_d = (level_d == '0);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;
    assign level_o = level_q;

endmodule

// File: rtl/sdram_write_queue.sv
// Posted CPU byte-write queue draining into the SDRAM/VGA controller port,
// dropping writes that repeat the controller's last-written address.
module sdram_write_queue
    import sdram_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = sdram_pkg::AW
) (
    input  logic                     clock_100_mhz,
    input  logic                     reset_n,
    input  logic [AW-1:0]            cpu_address,
    input  logic [7:0]               cpu_data,
    input  logic                     cpu_we,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic [7:0]               o_dup_count,
    output logic [AW-1:0]            m_address,
    output logic [7:0]               m_data,
    output logic                     m_we,
    input  logic                     m_ready
);

    drain_state_e  state_q, state_d;
    logic [1:0]    guard_q, guard_d;
    logic [AW-1:0] m_address_q, m_address_d;
    logic [7:0]    m_data_q, m_data_d;
    logic          m_we_q, m_we_d;
    logic [AW-1:0] last_addr_q, last_addr_d;
    logic          last_valid_q, last_valid_d;
    logic [7:0]    dup_q, dup_d;
    logic          pop;
    logic [AW+7:0] head;
    logic [AW-1:0] head_addr;
    logic [7:0]    head_data;

    sync_fifo #(
        .WIDTH(AW + 8),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk_i   (clock_100_mhz),
        .rst_ni  (reset_n),
        .push_i  (cpu_we),
        .wdata_i ({cpu_address, cpu_data}),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (o_full),
        .empty_o (o_empty),
        .level_o (o_level)
    );

    assign head_addr = head[AW+7:8];
    assign head_data = head[7:0];

    always_comb begin
        state_d      = state_q;
        guard_d      = guard_q;
        m_address_d  = m_address_q;
        m_data_d     = m_data_q;
        m_we_d       = m_we_q;
        last_addr_d  = last_addr_q;
        last_valid_d = last_valid_q;
        dup_d        = dup_q;
        pop          = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!o_empty) begin
                    // The controller would ignore this write, so retire it here.
                    if (last_valid_q && (head_addr == last_addr_q)) begin
                        pop   = 1'b1;
                        dup_d = sat_inc8(dup_q);
                    end else begin
                        m_address_d = head_addr;
                        m_data_d    = head_data;
                        m_we_d      = 1'b1;
                        guard_d     = GUARD_INIT;
                        state_d     = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                guard_d = guard_q - 2'd1;
                if (guard_q == 2'd1) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (m_ready) begin
                    m_we_d       = 1'b0;
                    pop          = 1'b1;
                    last_addr_d  = m_address_q;
                    last_valid_d = 1'b1;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock_100_mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            guard_q      <= '0;
            m_address_q  <= '0;
            m_data_q     <= '0;
            m_we_q       <= 1'b0;
            last_addr_q  <= '0;
            last_valid_q <= 1'b1;
            dup_q        <= '0;
        end else begin
            state_q      <= state_d;
            guard_q      <= guard_d;
            m_address_q  <= m_address_d;
            m_data_q     <= m_data_d;
            m_we_q       <= m_we_d;
            last_addr_q  <= last_addr_d;
            last_valid_q <= last_valid_d;
            dup_q        <= dup_d;
        end
    end

    assign m_address   = m_address_q;
    assign m_data      = m_data_q;
    assign m_we        = m_we_q;
    assign o_dup_count = dup_q;

endmodule

// File: tb/tb_sdram_write_queue.sv
// Directed bench for sdram_write_queue; issued writes are logged on each m_we rise.
module tb_sdram_write_queue;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [25:0] cpu_address;
    logic [7:0]  cpu_data;
    logic        cpu_we;
    logic        o_full;
    logic        o_empty;
    logic [4:0]  o_level;
    logic [7:0]  o_dup_count;
    logic [25:0] m_address;
    logic [7:0]  m_data;
    logic        m_we;
    logic        m_ready;

    int n_checks = 0;
    int n_fail   = 0;

    logic [25:0] iss_addr[$];
    logic [7:0]  iss_data[$];
    logic        prev_we = 1'b0;

    always #5 clk = ~clk;

    sdram_write_queue #(.DEPTH(16), .AW(26)) dut (
        .clock_100_mhz (clk),
        .reset_n       (reset_n),
        .cpu_address   (cpu_address),
        .cpu_data      (cpu_data),
        .cpu_we        (cpu_we),
        .o_full        (o_full),
        .o_empty       (o_empty),
        .o_level       (o_level),
        .o_dup_count   (o_dup_count),
        .m_address     (m_address),
        .m_data        (m_data),
        .m_we          (m_we),
        .m_ready       (m_ready)
    );

    always @(negedge clk) begin
        if (m_we && !prev_we) begin
            iss_addr.push_back(m_address);
            iss_data.push_back(m_data);
        end
        prev_we = m_we;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [25:0] a, input logic [7:0] d);
        cpu_address = a;
        cpu_data    = d;
        cpu_we      = 1'b1;
        tick();
        cpu_we      = 1'b0;
    endtask

    task automatic run_until_idle(input int bound, output int cycles);
        cycles = 0;
        while (cycles < bound) begin
            tick();
            cycles++;
            if (o_empty && !m_we) break;
        end
    endtask

    task automatic clear_log();
        iss_addr.delete();
        iss_data.delete();
    endtask

    task automatic test_reset();
        reset_n = 1'b0; cpu_we = 1'b0; cpu_address = '0; cpu_data = '0; m_ready = 1'b1;
        repeat (3) tick();
        n_checks++; if (o_full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b want 0", o_full); end
        n_checks++; if (o_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b want 1", o_empty); end
        n_checks++; if (o_level !== 5'd0) begin n_fail++; $display("FAIL reset_level got %0d want 0", o_level); end
        n_checks++; if (o_dup_count !== 8'd0) begin n_fail++; $display("FAIL reset_dup got %0d want 0", o_dup_count); end
        n_checks++; if (m_we !== 1'b0) begin n_fail++; $display("FAIL reset_we got %b want 0", m_we); end
        n_checks++; if (m_address !== 26'd0 || m_data !== 8'd0) begin n_fail++; $display("FAIL reset_mport got %h/%h want 0/0", m_address, m_data); end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_dup_after_reset();
        int cyc;
        logic seen_we;
        clear_log();
        m_ready = 1'b1;
        push(26'h0, 8'h11);
        n_checks++; if (o_level !== 5'd1) begin n_fail++; $display("FAIL dup0_level_push got %0d want 1", o_level); end
        tick();
        n_checks++; if (o_dup_count !== 8'd1) begin n_fail++; $display("FAIL dup0_count got %0d want 1", o_dup_count); end
        n_checks++; if (o_level !== 5'd0 || o_empty !== 1'b1) begin n_fail++; $display("FAIL dup0_drop got level %0d empty %b want 0/1", o_level, o_empty); end
        seen_we = 1'b0;
        repeat (5) begin
            if (m_we) seen_we = 1'b1;
            tick();
        end
        n_checks++; if (seen_we !== 1'b0 || iss_addr.size() != 0) begin n_fail++; $display("FAIL dup0_no_issue got we_seen %b issued %0d want 0/0", seen_we, iss_addr.size()); end
        push(26'h1, 8'h22);
        run_until_idle(50, cyc);
        n_checks++; if (cyc >= 50) begin n_fail++; $display("FAIL dup0_addr1_timeout got %0d cycles want <50", cyc); end
        n_checks++;
        if (iss_addr.size() != 1) begin
            n_fail++; $display("FAIL addr1_issue got %0d writes want 1", iss_addr.size());
        end else if (iss_addr[0] !== 26'h1 || iss_data[0] !== 8'h22) begin
            n_fail++; $display("FAIL addr1_issue got %h/%h want 1/22", iss_addr[0], iss_data[0]);
        end
    endtask

    task automatic test_single_write();
        int we_cycles;
        clear_log();
        m_ready = 1'b1;
        push(26'h0001234, 8'h5A);
        n_checks++; if (o_level !== 5'd1 || o_empty !== 1'b0) begin n_fail++; $display("FAIL single_push got level %0d empty %b want 1/0", o_level, o_empty); end
        n_checks++; if (m_we !== 1'b0) begin n_fail++; $display("FAIL single_we_early got %b want 0", m_we); end
        tick();
        n_checks++; if (m_we !== 1'b1 || m_address !== 26'h0001234 || m_data !== 8'h5A) begin
            n_fail++; $display("FAIL single_issue got we %b %h/%h want 1 0001234/5a", m_we, m_address, m_data); end
        m_ready = 1'b0;
        we_cycles = 1;
        repeat (3) begin
            tick();
            if (m_we) we_cycles++;
        end
        m_ready = 1'b1;
        tick();
        n_checks++; if (we_cycles != 4) begin n_fail++; $display("FAIL single_we_len got %0d want 4", we_cycles); end
        n_checks++; if (m_we !== 1'b0 || o_empty !== 1'b1 || o_level !== 5'd0) begin
            n_fail++; $display("FAIL single_pop got we %b empty %b level %0d want 0/1/0", m_we, o_empty, o_level); end
        n_checks++; if (iss_addr.size() != 1) begin n_fail++; $display("FAIL single_count got %0d want 1", iss_addr.size()); end
    endtask

    task automatic test_fill_full();
        int cyc;
        int bad;
        logic [25:0] ea;
        logic [7:0]  ed;
        clear_log();
        m_ready = 1'b0;
        for (int i = 0; i < 16; i++) push(26'h10 + 26'(i), 8'hA0 + 8'(i));
        n_checks++; if (o_full !== 1'b1 || o_level !== 5'd16) begin n_fail++; $display("FAIL fill_16 got full %b level %0d want 1/16", o_full, o_level); end
        push(26'h99, 8'hEE);
        n_checks++; if (o_full !== 1'b1 || o_level !== 5'd16) begin n_fail++; $display("FAIL fill_17 got full %b level %0d want 1/16", o_full, o_level); end
        n_checks++; if (m_we !== 1'b1 || m_address !== 26'h10) begin n_fail++; $display("FAIL fill_head got we %b addr %h want 1/10", m_we, m_address); end
        m_ready = 1'b1;
        run_until_idle(200, cyc);
        n_checks++; if (cyc != 61) begin n_fail++; $display("FAIL fill_drain_time got %0d cycles want 61", cyc); end
        n_checks++; if (o_full !== 1'b0) begin n_fail++; $display("FAIL fill_not_full got %b want 0", o_full); end
        n_checks++;
        if (iss_addr.size() != 16) begin
            n_fail++; $display("FAIL fill_count got %0d want 16", iss_addr.size());
        end else begin
            bad = 0;
            for (int i = 0; i < 16; i++) begin
                ea = 26'h10 + 26'(i);
                ed = 8'hA0 + 8'(i);
                if (iss_addr[i] !== ea || iss_data[i] !== ed) begin
                    if (bad == 0) $display("FAIL fill_order entry %0d got %h/%h want %h/%h", i, iss_addr[i], iss_data[i], ea, ed);
                    bad++;
                end
            end
            if (bad != 0) n_fail++;
        end
    endtask

    task automatic test_dup_sequence();
        int cyc;
        clear_log();
        m_ready = 1'b1;
        push(26'h40, 8'h01);
        push(26'h40, 8'h02);
        push(26'h41, 8'h03);
        run_until_idle(100, cyc);
        n_checks++; if (cyc >= 100) begin n_fail++; $display("FAIL dupseq_timeout got %0d cycles want <100", cyc); end
        n_checks++; if (o_dup_count !== 8'd2) begin n_fail++; $display("FAIL dupseq_count got %0d want 2", o_dup_count); end
        n_checks++;
        if (iss_addr.size() != 2) begin
            n_fail++; $display("FAIL dupseq_issue got %0d writes want 2", iss_addr.size());
        end else if (iss_addr[0] !== 26'h40 || iss_data[0] !== 8'h01 || iss_addr[1] !== 26'h41 || iss_data[1] !== 8'h03) begin
            n_fail++; $display("FAIL dupseq_issue got %h/%h %h/%h want 40/01 41/03", iss_addr[0], iss_data[0], iss_addr[1], iss_data[1]);
        end
    endtask

    task automatic test_long_stall();
        int unstable;
        clear_log();
        m_ready = 1'b0;
        push(26'h200, 8'h3C);
        tick();
        unstable = 0;
        for (int i = 0; i < 700; i++) begin
            if (m_we !== 1'b1 || m_address !== 26'h200 || m_data !== 8'h3C) unstable++;
            tick();
        end
        n_checks++; if (unstable != 0) begin n_fail++; $display("FAIL stall_stable got %0d unstable cycles want 0", unstable); end
        n_checks++; if (m_we !== 1'b1) begin n_fail++; $display("FAIL stall_hold got we %b want 1", m_we); end
        m_ready = 1'b1;
        tick();
        n_checks++; if (m_we !== 1'b0 || o_empty !== 1'b1) begin n_fail++; $display("FAIL stall_release got we %b empty %b want 0/1", m_we, o_empty); end
        n_checks++; if (iss_addr.size() != 1) begin n_fail++; $display("FAIL stall_count got %0d want 1", iss_addr.size()); end
    endtask

    task automatic test_reset_mid();
        int cyc;
        m_ready = 1'b0;
        push(26'h300, 8'h30);
        push(26'h301, 8'h31);
        push(26'h302, 8'h32);
        repeat (6) tick();
        n_checks++; if (m_we !== 1'b1 || o_level !== 5'd3) begin n_fail++; $display("FAIL mid_pre got we %b level %0d want 1/3", m_we, o_level); end
        reset_n = 1'b0;
        #2;
        n_checks++; if (m_we !== 1'b0 || o_level !== 5'd0 || o_empty !== 1'b1 || o_dup_count !== 8'd0) begin
            n_fail++; $display("FAIL mid_reset got we %b level %0d empty %b dup %0d want 0/0/1/0", m_we, o_level, o_empty, o_dup_count); end
        tick();
        reset_n = 1'b1;
        m_ready = 1'b1;
        tick();
        clear_log();
        push(26'h100, 8'h77);
        run_until_idle(50, cyc);
        n_checks++; if (cyc >= 50) begin n_fail++; $display("FAIL mid_post_timeout got %0d cycles want <50", cyc); end
        n_checks++;
        if (iss_addr.size() != 1) begin
            n_fail++; $display("FAIL mid_post_issue got %0d writes want 1", iss_addr.size());
        end else if (iss_addr[0] !== 26'h100 || iss_data[0] !== 8'h77) begin
            n_fail++; $display("FAIL mid_post_issue got %h/%h want 100/77", iss_addr[0], iss_data[0]);
        end
        n_checks++; if (o_dup_count !== 8'd0) begin n_fail++; $display("FAIL mid_post_dup got %0d want 0", o_dup_count); end
    endtask

    initial begin
        test_reset();
        test_dup_after_reset();
        test_single_write();
        test_fill_full();
        test_dup_sequence();
        test_long_stall();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sdram_write_queue.md
# sdram_write_queue

Posted-write queue between the CPU bus and the SDRAM/VGA controller, in the `clock_100_mhz` domain. Accepts single-cycle byte writes from the CPU into a FIFO and drains them one at a time into the controller's `i_address`/`i_we`/`i_data`/`o_ready` port. The CPU never stalls on video line refills. The block also absorbs the controller's rule that a write whose address equals the previously written address is ignored.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, 4..256.
- `AW`, 26: byte address width; matches the 64 MB controller address.
- `clock_100_mhz`  in  1  controller clock; all logic on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cpu_address`  in  AW  byte address of the write.
- `cpu_data`  in  8  write byte.
- `cpu_we`  in  1  one-cycle write strobe; accepted when `o_full`=0.
- `o_full`  out  1  FIFO holds DEPTH entries; reset 0.
- `o_empty`  out  1  FIFO holds no entries; reset 1.
- `o_level`  out  log2(DEPTH)+1  current FIFO occupancy; reset 0.
- `o_dup_count`  out  8  saturating count of dropped same-address writes; reset 0.
- `m_address`  out  AW  to controller `i_address`, registered; reset 0.
- `m_data`  out  8  to controller `i_data`, registered; reset 0.
- `m_we`  out  1  to controller `i_we`, registered; reset 0.
- `m_ready`  in  1  from controller `o_ready`.

## Operation
- Push: on an edge with `cpu_we`=1 and `o_full`=0, `{cpu_address,cpu_data}` is written at the tail.
  - `cpu_we` while full is dropped silently. It is not counted.
  - Push and pop on the same edge are both legal; the level is unchanged.
- Shadow register `last_addr`/`last_valid` mirrors the controller's last-written address.
  - Reset values: `last_addr`=0, `last_valid`=1, because the controller powers up with its last write address at 0.
- Drain FSM states: IDLE, ISSUE, WAIT.
  - IDLE, FIFO empty: stay in IDLE.
  - IDLE, head address == `last_addr` and `last_valid`=1: pop the head without issuing it, increment `o_dup_count` (saturates at 255), stay in IDLE.
  - IDLE, other head: load the head into `m_address`/`m_data`, set `m_we`=1, load the guard counter with 2, go to ISSUE.
  - ISSUE: decrement the guard counter; `m_ready` is ignored. Go to WAIT when the counter reaches 0. This covers the controller's one-cycle delay before it drops `o_ready`.
  - WAIT, `m_ready`=1: set `m_we`=0, pop the head, set `last_addr` to `m_address`, go to IDLE.
  - WAIT, `m_ready`=0: hold `m_we`, `m_address` and `m_data` stable. A video line refill or the initial chip init may stretch this phase without bound.
- `m_address`/`m_data` may change only on the IDLE→ISSUE transition.
- Reset asserted mid-operation:
  - `m_we`, FIFO pointers, level, FSM and `o_dup_count` clear immediately.
  - A write already taken by the controller still completes in SDRAM.
  - `last_addr` returns to 0. A post-reset write to an address other than the one being completed is still issued correctly.

## Timing
- Push at edge N: `o_empty` falls and `o_level` increments after edge N.
- Empty queue, push at edge N: `m_we` rises after edge N+1.
- `m_ready` is first sampled at edge N+4.
- Minimum drain period: 4 cycles per non-duplicate entry. Each duplicate drop costs 1 cycle.
- `o_full` and `o_level` are registered and exact on every cycle. There is no almost-full.
- FIFO read is combinational from the head register or array. No memory-block read latency is allowed.

## Structure
- Shared package `sdram_pkg`: `AW`, the FSM state encoding, and the guard constant 2.
  - The controller's refill lines reuse this package.
- One sub-module, `sync_fifo`: parameterised width = AW+8 and DEPTH, with push/pop/full/empty/level.
  - The drain FSM, shadow register and duplicate counter live in the top block.

## Test plan
- Single write 0x0001234 data 0x5A, `m_ready` modelled after the controller: `m_we` high 4 cycles; pop on `m_ready` return; `o_empty`=1 after the pop.
- Write to address 0 right after reset: dropped, `o_dup_count`=1, `m_we` never asserted. Then write to 0x0000001: issued.
- Fill 16 writes to 0x10..0x1F with `m_ready`=0, then a 17th push: `o_full`=1, `o_level`=16, the 17th is lost. Release `m_ready`: the 16 entries drain in order with correct data.
- Writes to 0x40, 0x40, 0x41: 0x40 issued once, `o_dup_count`=1, 0x41 issued.
- `m_ready` held low 700 cycles during ISSUE/WAIT (line refill): `m_we`/`m_address`/`m_data` stable throughout; completes on the first `m_ready`=1 in WAIT.
- `reset_n` pulsed low in WAIT with 3 entries queued: after reset `m_we`=0, `o_level`=0, `o_empty`=1, `o_dup_count`=0. The next push to 0x100 is issued normally.
